factor_check_seq: RTL and testbench

//  Sequential, parametrised factorization checker: accepts operands i1, i2 (W bits each) and

---
 rtl/factor_pkg.sv | 18 +
 rtl/factor_mul_dp.sv | 41 ++++
 rtl/factor_check_seq.sv | 113 +++++++++++
 tb/tb_factor_check_seq.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/factor_pkg.sv
// Shared types and sizing helpers for the sequential factorization checker.
// Used by factor_check_seq and factor_mul_dp.
package factor_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int W_DEFAULT = 6;

  // Counter must be able to hold W itself.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/factor_mul_dp.sv
// Shift-add multiplier datapath: one multiplier bit is consumed per step,
// accumulating a 2W-bit product that cannot overflow.
module factor_mul_dp
  import factor_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_load,
  input  logic           i_step,
  input  logic [W-1:0]   i_mcand,
  input  logic [W-1:0]   i_mplier,
  output logic [2*W-1:0] o_acc
);

  logic [2*W-1:0] r_mcand;
  logic [W-1:0]   r_mplier;
  logic [2*W-1:0] r_acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
    end else if (i_load) begin
      r_mcand  <= {{W{1'b0}}, i_mcand};
      r_mplier <= i_mplier;
      r_acc    <= '0;
    end else if (i_step) begin
      if (r_mplier[0]) begin
        r_acc <= r_acc + r_mcand;
      end
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/factor_check_seq.sv
// Sequential factorization checker: reports whether a == i1*i2 after W shift-add cycles.
// Optional macro FACTOR_NONTRIVIAL_EN additionally requires i1>=2 and i2>=2 for is_factor.
module factor_check_seq
  import factor_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   i1,
  input  logic [W-1:0]   i2,
  input  logic [2*W-1:0] a,
  output logic           res_valid,
  input  logic           res_ready,
  output logic           is_factor,
  output logic [2*W-1:0] product
);

  localparam int CNT_W = cnt_width(W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(W - 1);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [2*W-1:0]   r_a;
  logic [2*W-1:0]   w_acc;
  logic             w_load;
  logic             w_step;
  logic             w_match;

  factor_mul_dp #(.W(W)) u_dp (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_load),
    .i_step   (w_step),
    .i_mcand  (i1),
    .i_mplier (i2),
    .o_acc    (w_acc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_load    = 1'b0;
    w_step    = 1'b0;
    in_ready  = 1'b0;
    res_valid = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_load = 1'b1;
          w_next = RUN;
        end
      end
      RUN: begin
        w_step = 1'b1;
        if (r_cnt == LAST_CNT) begin
          w_next = DONE;
        end
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_a   <= '0;
    end else if (w_load) begin
      r_cnt <= '0;
      r_a   <= a;
    end else if (w_step) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign w_match = (w_acc == r_a);
  assign product = (r_state == DONE) ? w_acc : '0;

`ifdef FACTOR_NONTRIVIAL_EN
  logic r_nontriv;

  // Decided at accept time so operands need not be held for the whole job.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_nontriv <= 1'b0;
    end else if (w_load) begin
      r_nontriv <= (i1 > W'(1)) && (i2 > W'(1));
    end
  end

  assign is_factor = (r_state == DONE) && w_match && r_nontriv;
`else
  assign is_factor = (r_state == DONE) && w_match;
`endif

endmodule

// File: tb/tb_factor_check_seq.sv
// Self-checking bench: W=6 and W=8 instances run the same jobs in lockstep
// against a timeline model of the handshake and an arithmetic model of the result.
module tb_factor_check_seq;

`ifdef FACTOR_NONTRIVIAL_EN
  localparam bit NT = 1'b1;
`else
  localparam bit NT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        res_ready;
  logic [7:0]  i1;
  logic [7:0]  i2;
  logic [15:0] a;

  logic        inReady6, resValid6, isFactor6;
  logic [11:0] product6;
  logic        inReady8, resValid8, isFactor8;
  logic [15:0] product8;

  always #5 clk = ~clk;

  factor_check_seq #(.W(6)) dut6 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (inReady6),
    .i1        (i1[5:0]),
    .i2        (i2[5:0]),
    .a         (a[11:0]),
    .res_valid (resValid6),
    .res_ready (res_ready),
    .is_factor (isFactor6),
    .product   (product6)
  );

  factor_check_seq #(.W(8)) dut8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (inReady8),
    .i1        (i1),
    .i2        (i2),
    .a         (a),
    .res_valid (resValid8),
    .res_ready (res_ready),
    .is_factor (isFactor8),
    .product   (product8)
  );

  int errors = 0;
  int checks = 0;
  bit cmpOn  = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Arithmetic model: operands truncated to each instance's width
  function automatic int modelProduct(input int w, input int x, input int y);
    int m;
    m = (1 << w) - 1;
    return (x & m) * (y & m);
  endfunction

  function automatic bit modelFactor(input int w, input int x, input int y, input int t);
    int m;
    bit ok;
    m  = (1 << w) - 1;
    ok = (modelProduct(w, x, y) == (t & ((1 << (2 * w)) - 1)));
    if (NT) ok = ok && ((x & m) >= 2) && ((y & m) >= 2);
    return ok;
  endfunction

  // Timeline model: accept when idle, busy W cycles, then hold result until taken
  int wOf[2]   = '{6, 8};
  bit mIdle[2] = '{1'b1, 1'b1};
  bit mPend[2] = '{1'b0, 1'b0};
  int mBusy[2] = '{0, 0};
  int mProd[2] = '{0, 0};
  bit mFac[2]  = '{1'b0, 1'b0};

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        mIdle[k] = 1'b1;
        mPend[k] = 1'b0;
        mBusy[k] = 0;
      end else if (mIdle[k]) begin
        if (in_valid) begin
          mIdle[k] = 1'b0;
          mBusy[k] = wOf[k];
          mProd[k] = modelProduct(wOf[k], int'(i1), int'(i2));
          mFac[k]  = modelFactor(wOf[k], int'(i1), int'(i2), int'(a));
        end
      end else if (mBusy[k] > 0) begin
        mBusy[k] = mBusy[k] - 1;
        if (mBusy[k] == 0) mPend[k] = 1'b1;
      end else if (mPend[k] && res_ready) begin
        mPend[k] = 1'b0;
        mIdle[k] = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (cmpOn) begin
      checkOutput("in_ready6", 32'(inReady6), 32'(mIdle[0]));
      checkOutput("res_valid6", 32'(resValid6), 32'(mPend[0]));
      if (mPend[0]) begin
        checkOutput("product6", 32'(product6), 32'(mProd[0]));
        checkOutput("is_factor6", 32'(isFactor6), 32'(mFac[0]));
      end
      checkOutput("in_ready8", 32'(inReady8), 32'(mIdle[1]));
      checkOutput("res_valid8", 32'(resValid8), 32'(mPend[1]));
      if (mPend[1]) begin
        checkOutput("product8", 32'(product8), 32'(mProd[1]));
        checkOutput("is_factor8", 32'(isFactor8), 32'(mFac[1]));
      end
    end
  end

  task automatic checkIdleLiterals(input string tag);
    checkOutput({tag, "_in_ready6"}, 32'(inReady6), 32'd1);
    checkOutput({tag, "_res_valid6"}, 32'(resValid6), 32'd0);
    checkOutput({tag, "_product6"}, 32'(product6), 32'd0);
    checkOutput({tag, "_is_factor6"}, 32'(isFactor6), 32'd0);
    checkOutput({tag, "_in_ready8"}, 32'(inReady8), 32'd1);
    checkOutput({tag, "_res_valid8"}, 32'(resValid8), 32'd0);
    checkOutput({tag, "_product8"}, 32'(product8), 32'd0);
    checkOutput({tag, "_is_factor8"}, 32'(isFactor8), 32'd0);
  endtask

  // One job on both instances; hold>0 keeps res_ready low and pokes in_valid meanwhile
  task automatic applyStimulus(input int x, input int y, input int t, input int hold,
                               input int expProd6, input int expProd8,
                               input int expFac6, input int expFac8);
    int lat6;
    int lat8;
    int cyc;
    logic [15:0] p6;
    logic [15:0] p8;
    logic f6;
    logic f8;
    lat6 = -1;
    lat8 = -1;
    p6   = '0;
    p8   = '0;
    f6   = 1'b0;
    f8   = 1'b0;
    @(negedge clk);
    i1        = 8'(x);
    i2        = 8'(y);
    a         = 16'(t);
    in_valid  = 1'b1;
    res_ready = (hold == 0);
    @(negedge clk);
    in_valid = 1'b0;
    cyc      = 1;
    while (cyc < 60) begin
      if (resValid6 && lat6 < 0) begin
        lat6 = cyc;
        p6   = 16'(product6);
        f6   = isFactor6;
      end
      if (resValid8 && lat8 < 0) begin
        lat8 = cyc;
        p8   = product8;
        f8   = isFactor8;
      end
      if (lat6 >= 0 && lat8 >= 0) break;
      @(negedge clk);
      cyc++;
    end
    checkOutput("latency6", 32'(lat6), 32'd7);
    checkOutput("latency8", 32'(lat8), 32'd9);
    checkOutput("job_product6", 32'(p6), 32'(expProd6));
    checkOutput("job_product8", 32'(p8), 32'(expProd8));
    checkOutput("job_is_factor6", 32'(f6), 32'(expFac6));
    checkOutput("job_is_factor8", 32'(f8), 32'(expFac8));
    if (hold > 0) begin
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        in_valid = h[0];
        i1       = 8'(x + 1);
      end
      @(negedge clk);
      in_valid  = 1'b0;
      res_ready = 1'b1;
      @(negedge clk);
      checkOutput("released_in_ready6", 32'(inReady6), 32'd1);
      checkOutput("released_in_ready8", 32'(inReady8), 32'd1);
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    res_ready = 1'b0;
    i1        = '0;
    i2        = '0;
    a         = '0;
    repeat (3) @(negedge clk);
    $display("[TB] checking reset state");
    checkIdleLiterals("reset");
    rst   = 1'b0;
    cmpOn = 1'b1;

    applyStimulus(7, 9, 63, 0, 63, 63, 1, 1);
    applyStimulus(7, 9, 64, 0, 63, 63, 0, 0);
    applyStimulus(1, 63, 63, 0, 63, 63, NT ? 0 : 1, NT ? 0 : 1);
    applyStimulus(63, 63, 3969, 0, 3969, 3969, 1, 1);
    applyStimulus(3, 21, 63, 5, 63, 63, 1, 1);

    $display("[TB] reset during RUN");
    @(negedge clk);
    i1        = 8'd7;
    i2        = 8'd9;
    a         = 16'd63;
    in_valid  = 1'b1;
    res_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkIdleLiterals("midrun_reset");
    applyStimulus(5, 13, 65, 0, 65, 65, 1, 1);

    applyStimulus(15, 17, 255, 0, 255, 255, 1, 1);
    applyStimulus(255, 255, 65025, 0, 3969, 65025, 0, 1);
    applyStimulus(0, 37, 0, 0, 0, 0, NT ? 0 : 1, NT ? 0 : 1);

    repeat (2) @(negedge clk);
    cmpOn = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
